// File: rtl/ps_wide_len_meter.sv
// Wide PacketStream pass-through with a 2-entry FWFT buffer and a per-packet
// length side-channel (length in narrow words, saturating at 2^LENW-1).
module ps_wide_len_meter #(
    parameter int WIDTH = 8,
    parameter int COUNT = 16,
    parameter int LENW  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [COUNT*WIDTH-1:0]     i_dat,
    input  logic [$clog2(COUNT)-1:0]   i_mty,
    input  logic                       i_val,
    input  logic                       i_eop,
    output logic                       i_rdy,
    output logic [COUNT*WIDTH-1:0]     o_dat,
    output logic [$clog2(COUNT)-1:0]   o_mty,
    output logic                       o_val,
    output logic                       o_eop,
    input  logic                       o_rdy,
    output logic [LENW-1:0]            l_len,
    output logic                       l_val,
    input  logic                       l_rdy
);

    localparam int DW = COUNT * WIDTH;
    localparam int MW = $clog2(COUNT);
    // Wide enough that cnt + COUNT never wraps, even when COUNT > 2^LENW.
    localparam int SW = LENW + MW + 2;
    localparam logic [SW-1:0] LMAX = (SW'(1) << LENW) - SW'(1);

    logic [DW-1:0]   h_dat, t_dat;
    logic [MW-1:0]   h_mty, t_mty;
    logic            h_eop, t_eop;
    logic [1:0]      fill;
    logic            full, push, pop;

    logic [LENW-1:0] cnt;
    logic [SW-1:0]   acc_sum, len_sum;
    logic [LENW-1:0] acc_sat, len_sat;

    assign full  = (fill == 2'd2);
    assign i_rdy = ~reset & ~full & ~(l_val & ~l_rdy);
    assign push  = i_val & i_rdy;
    assign o_val = (fill != 2'd0);
    assign pop   = o_val & o_rdy;

    assign o_dat = h_dat;
    assign o_mty = h_mty;
    assign o_eop = h_eop;

    assign acc_sum = SW'(cnt) + SW'(COUNT);
    assign len_sum = acc_sum - SW'(i_mty);
    assign acc_sat = (acc_sum > LMAX) ? LMAX[LENW-1:0] : acc_sum[LENW-1:0];
    assign len_sat = (len_sum > LMAX) ? LMAX[LENW-1:0] : len_sum[LENW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            h_dat <= '0;
            h_mty <= '0;
            h_eop <= 1'b0;
            t_dat <= '0;
            t_mty <= '0;
            t_eop <= 1'b0;
            fill  <= 2'd0;
        end else begin
            if (pop) begin
                if (fill == 2'd2) begin
                    h_dat <= t_dat;
                    h_mty <= t_mty;
                    h_eop <= t_eop;
                    fill  <= 2'd1;
                end else if (push) begin
                    h_dat <= i_dat;
                    h_mty <= i_mty;
                    h_eop <= i_eop;
                end else begin
                    fill <= 2'd0;
                end
            end else if (push) begin
                if (fill == 2'd0) begin
                    h_dat <= i_dat;
                    h_mty <= i_mty;
                    h_eop <= i_eop;
                    fill  <= 2'd1;
                end else begin
                    t_dat <= i_dat;
                    t_mty <= i_mty;
                    t_eop <= i_eop;
                    fill  <= 2'd2;
                end
            end
        end
    end

    // A new eop may reload the length on the same edge the old one is taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            l_len <= '0;
            l_val <= 1'b0;
        end else begin
            if (push) begin
                if (i_eop) begin
                    cnt   <= '0;
                    l_len <= len_sat;
                    l_val <= 1'b1;
                end else begin
                    cnt <= acc_sat;
                    if (l_rdy) l_val <= 1'b0;
                end
            end else if (l_rdy) begin
                l_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps_wide_len_meter.sv
// Scoreboard bench for ps_wide_len_meter: directed scenarios plus randomized
// packets checked against a packet-level length model.
module tb_ps_wide_len_meter;

    localparam int WIDTH = 8;
    localparam int COUNT = 16;
    localparam int LENW  = 16;
    localparam int DW    = WIDTH * COUNT;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] i_dat;
    logic [3:0]    i_mty;
    logic          i_val, i_eop, i_rdy;
    logic [DW-1:0] o_dat;
    logic [3:0]    o_mty;
    logic          o_val, o_eop, o_rdy;
    logic [15:0]   l_len;
    logic          l_val, l_rdy;

    logic [DW-1:0] i_dat6, o_dat6;
    logic [3:0]    i_mty6, o_mty6;
    logic          i_val6, i_eop6, i_rdy6, o_val6, o_eop6, o_rdy6;
    logic [5:0]    l_len6;
    logic          l_val6, l_rdy6;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [3:0]    m;
        logic          e;
    } beat_t;

    beat_t bq[$];
    int    lq[$];
    int    pkt_beats = 0;

    always #5 clk = ~clk;

    ps_wide_len_meter #(.WIDTH(WIDTH), .COUNT(COUNT), .LENW(LENW)) dut (
        .clk(clk), .reset(reset),
        .i_dat(i_dat), .i_mty(i_mty), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
        .o_dat(o_dat), .o_mty(o_mty), .o_val(o_val), .o_eop(o_eop), .o_rdy(o_rdy),
        .l_len(l_len), .l_val(l_val), .l_rdy(l_rdy)
    );

    ps_wide_len_meter #(.WIDTH(WIDTH), .COUNT(COUNT), .LENW(6)) dut6 (
        .clk(clk), .reset(reset),
        .i_dat(i_dat6), .i_mty(i_mty6), .i_val(i_val6), .i_eop(i_eop6), .i_rdy(i_rdy6),
        .o_dat(o_dat6), .o_mty(o_mty6), .o_val(o_val6), .o_eop(o_eop6), .o_rdy(o_rdy6),
        .l_len(l_len6), .l_val(l_val6), .l_rdy(l_rdy6)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int model_len(input int beats, input int mty, input int lenw);
        int v, lim;
        v   = COUNT * beats - mty;
        lim = (1 << lenw) - 1;
        return (v > lim) ? lim : v;
    endfunction

    // Reference model: record every accepted beat and each packet's length.
    always @(negedge clk) begin
        if (reset) begin
            bq.delete();
            lq.delete();
            pkt_beats = 0;
        end else if (i_val && i_rdy) begin
            bq.push_back('{d: i_dat, m: i_mty, e: i_eop});
            pkt_beats++;
            if (i_eop) begin
                lq.push_back(model_len(pkt_beats, int'(i_mty), LENW));
                pkt_beats = 0;
            end
        end
    end

    always @(negedge clk) begin
        beat_t b;
        if (!reset && o_val && o_rdy) begin
            if (bq.size() == 0) begin
                check("beat_unexpected", 1, 0);
            end else begin
                b = bq.pop_front();
                check("o_dat", o_dat, b.d);
                check("o_mty", DW'(o_mty), DW'(b.m));
                check("o_eop", DW'(o_eop), DW'(b.e));
            end
        end
    end

    always @(negedge clk) begin
        int exp;
        if (!reset && l_val && l_rdy) begin
            if (lq.size() == 0) begin
                check("len_unexpected", 1, 0);
            end else begin
                exp = lq.pop_front();
                check("l_len", DW'(l_len), DW'(exp));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic          acc;
        int            nb, mty, tries;

        reset = 1'b1;
        i_dat = '0; i_mty = '0; i_val = 1'b0; i_eop = 1'b0;
        o_rdy = 1'b1; l_rdy = 1'b1;
        i_dat6 = '0; i_mty6 = '0; i_val6 = 1'b0; i_eop6 = 1'b0;
        o_rdy6 = 1'b1; l_rdy6 = 1'b1;

        // Reset state
        step();
        step();
        check("rst_i_rdy", DW'(i_rdy), 0);
        check("rst_o_val", DW'(o_val), 0);
        check("rst_l_val", DW'(l_val), 0);
        reset = 1'b0;
        #1;
        check("post_rst_i_rdy", DW'(i_rdy), 1);
        check("post_rst_o_dat", o_dat, 0);
        check("post_rst_o_mty", DW'(o_mty), 0);
        check("post_rst_o_eop", DW'(o_eop), 0);
        check("post_rst_l_len", DW'(l_len), 0);

        // Single-beat packet, mty=3
        d = {$urandom, $urandom, $urandom, $urandom};
        i_dat = d; i_mty = 4'd3; i_eop = 1'b1; i_val = 1'b1;
        step();
        i_val = 1'b0;
        check("t1_o_val", DW'(o_val), 1);
        check("t1_o_dat", o_dat, d);
        check("t1_l_val", DW'(l_val), 1);
        check("t1_l_len", DW'(l_len), 13);
        step();
        check("t1_l_val_pulse", DW'(l_val), 0);
        check("t1_o_val_gone", DW'(o_val), 0);

        // Three back-to-back beats, data = index
        for (int b = 0; b < 3; b++) begin
            i_dat = DW'(b); i_mty = 4'd0; i_eop = (b == 2); i_val = 1'b1;
            step();
        end
        i_val = 1'b0;
        check("t2_l_val", DW'(l_val), 1);
        check("t2_l_len", DW'(l_len), 48);
        step();

        // Length back-pressure blocks input
        l_rdy = 1'b0;
        i_dat = DW'(32'hA5); i_mty = 4'd3; i_eop = 1'b1; i_val = 1'b1;
        step();
        check("t4_i_rdy_block", DW'(i_rdy), 0);
        i_dat = DW'(32'h5A); i_mty = 4'd5;
        step();
        step();
        check("t4_l_len_hold", DW'(l_len), 13);
        check("t4_i_rdy_still", DW'(i_rdy), 0);
        l_rdy = 1'b1;
        #1;
        check("t4_i_rdy_open", DW'(i_rdy), 1);
        step();
        l_rdy = 1'b0; i_val = 1'b0;
        check("t4_l_val_reload", DW'(l_val), 1);
        check("t4_l_len_second", DW'(l_len), 11);
        l_rdy = 1'b1;
        step();
        check("t4_l_val_clear", DW'(l_val), 0);

        // Saturation with LENW=6
        check("t5_i_rdy", DW'(i_rdy6), 1);
        for (int b = 0; b < 5; b++) begin
            i_dat6 = DW'(b); i_mty6 = 4'd0; i_eop6 = (b == 4); i_val6 = 1'b1;
            step();
        end
        check("t5_l_val", DW'(l_val6), 1);
        check("t5_l_len_sat", DW'(l_len6), DW'(model_len(5, 0, 6)));
        i_dat6 = DW'(9); i_eop6 = 1'b1;
        step();
        i_val6 = 1'b0;
        check("t5_l_len_next", DW'(l_len6), 16);
        step();

        // Reset mid-packet with FIFO full
        o_rdy = 1'b0;
        for (int b = 0; b < 2; b++) begin
            i_dat = DW'(100 + b); i_mty = 4'd0; i_eop = 1'b0; i_val = 1'b1;
            step();
        end
        i_val = 1'b0;
        check("t6_full", DW'(i_rdy), 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t6_o_val", DW'(o_val), 0);
        check("t6_l_val", DW'(l_val), 0);
        o_rdy = 1'b1;
        i_dat = DW'(77); i_mty = 4'd0; i_eop = 1'b1; i_val = 1'b1;
        step();
        i_val = 1'b0;
        check("t6_l_len", DW'(l_len), 16);
        check("t6_o_dat", o_dat, DW'(77));
        step();

        // Randomized packets
        for (int p = 0; p < 100; p++) begin
            nb  = $urandom_range(1, 20);
            mty = $urandom_range(0, 15);
            for (int b = 0; b < nb; b++) begin
                i_dat = {$urandom, $urandom, $urandom, $urandom};
                i_eop = (b == nb - 1);
                i_mty = i_eop ? 4'(mty) : 4'($urandom_range(0, 15));
                acc = 1'b0;
                tries = 0;
                while (!acc && tries < 300) begin
                    i_val = ($urandom_range(0, 3) != 0);
                    o_rdy = ($urandom_range(0, 3) != 0);
                    l_rdy = ($urandom_range(0, 3) != 0);
                    @(negedge clk);
                    acc = i_val && i_rdy;
                    step();
                    tries++;
                end
                i_val = 1'b0;
                if (!acc) check("accept_timeout", 0, 1);
            end
        end

        o_rdy = 1'b1; l_rdy = 1'b1; i_val = 1'b0;
        for (int c = 0; c < 100 && (bq.size() != 0 || lq.size() != 0); c++) step();
        step();
        check("drain_beats", DW'(bq.size()), 0);
        check("drain_lens", DW'(lq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
